// File: rtl/dc_motor_pwm_ctrl.sv
// dc_motor_pwm_ctrl
// H-bridge PWM controller for a brushed DC motor. Takes a signed percent
// speed command and drives a clockwise / counterclockwise output pair.
// The command is sampled only at period boundaries and slew limited.
// Dead time is inserted on every direction change and around an active
// short-brake. All outputs are registered, so each PWM edge lags the
// counter value that causes it by one cycle.
module dc_motor_pwm_ctrl #(
   parameter int PERIOD_CYCLES = 100000,
   parameter int DEAD_CYCLES   = 1000,
   parameter int RAMP_STEP     = 5
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic              i_Enable,
   input  logic              i_Brake,
   input  logic signed [7:0] i_Speed,
   output logic              o_Clockwise,
   output logic              o_Counterclockwise,
   output logic              o_Period_Start,
   output logic signed [7:0] o_Duty_Applied,
   output logic              o_Braking
);

   localparam int STEP  = PERIOD_CYCLES / 100;
   localparam int CNT_W = $clog2(PERIOD_CYCLES);
   localparam int TH_W  = $clog2(PERIOD_CYCLES + 1);
   localparam int DC_W  = $clog2(DEAD_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [DC_W-1:0]  DEAD_LOAD = DC_W'(DEAD_CYCLES);
   localparam logic [TH_W-1:0]  STEP_TH   = TH_W'(STEP);
   localparam logic signed [8:0] RAMP_S9  = 9'(RAMP_STEP);
   localparam logic signed [7:0] RAMP_S8  = 8'(RAMP_STEP);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEAD,
      ST_RUN,
      ST_BRAKE
   } state_t;

   // Saturate the raw command to the -100..+100 percent range; -128 maps to -100.
   function automatic logic signed [7:0] clamp_pct(input logic signed [7:0] v);
      if (v > 8'sd100)
         return 8'sd100;
      if (v < -8'sd100)
         return -8'sd100;
      return v;
   endfunction

   // Move cur toward goal by at most RAMP_STEP; a zero step means jump straight there.
   function automatic logic signed [7:0] ramp_to(input logic signed [7:0] cur,
                                                 input logic signed [7:0] goal);
      logic signed [8:0] diff;
      diff = {goal[7], goal} - {cur[7], cur};
      if (RAMP_STEP == 0)
         return goal;
      if (diff > RAMP_S9)
         return cur + RAMP_S8;
      if (diff < -RAMP_S9)
         return cur - RAMP_S8;
      return goal;
   endfunction

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [DC_W-1:0]   dead_cnt, dead_nx;
   logic signed [7:0] applied, applied_nx;
   logic              brake_req, brake_req_nx;
   logic              last_valid, last_valid_nx;
   logic              last_neg, last_neg_nx;

   logic              at_zero;
   logic signed [7:0] speed_c;
   logic signed [7:0] goal;
   logic signed [7:0] ramped;
   logic signed [7:0] restart;
   logic              applied_pos, applied_neg;
   logic              speed_pos, speed_neg;
   logic              reversal;

   logic              cw_nx, ccw_nx, ps_nx, braking_nx;
   logic signed [7:0] duty_neg;
   logic [7:0]        duty_abs;
   logic [TH_W-1:0]   thresh;

   // Command conditioning: clamp, decide the ramp goal and detect a pending reversal.
   always_comb begin
      at_zero     = (cnt == '0);
      speed_c     = clamp_pct(i_Speed);
      applied_pos = !applied[7] && (applied != 8'sd0);
      applied_neg = applied[7];
      speed_pos   = !speed_c[7] && (speed_c != 8'sd0);
      speed_neg   = speed_c[7];
      // A sign change always ramps through zero first.
      goal        = ((applied_pos && speed_neg) || (applied_neg && speed_pos)) ? 8'sd0 : speed_c;
      ramped      = ramp_to(applied, goal);
      restart     = ramp_to(8'sd0, speed_c);
      reversal    = (applied == 8'sd0) && last_valid && (last_neg ? speed_pos : speed_neg);
   end

   // PWM period counter; parked at zero while disabled.
   always_comb begin
      cnt_nx = '0;
      if (i_Enable)
         cnt_nx = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
   end

   // Controller FSM next-state, dead-time counter and applied duty update.
   always_comb begin
      state_nx      = state;
      dead_nx       = dead_cnt;
      applied_nx    = applied;
      brake_req_nx  = brake_req;
      last_valid_nx = last_valid;
      last_neg_nx   = last_neg;
      if (!i_Enable) begin
         state_nx      = ST_IDLE;
         dead_nx       = '0;
         applied_nx    = 8'sd0;
         brake_req_nx  = 1'b0;
         last_valid_nx = 1'b0;
         last_neg_nx   = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nx   = ST_DEAD;
               dead_nx    = DEAD_LOAD;
               applied_nx = 8'sd0;
            end
            ST_DEAD: begin
               applied_nx = 8'sd0;
               // A brake request dropped during dead time is simply forgotten.
               brake_req_nx = brake_req && i_Brake;
               if (dead_cnt != '0) begin
                  dead_nx = dead_cnt - DC_W'(1);
               end else if (brake_req && i_Brake) begin
                  state_nx = ST_BRAKE;
               end else if (at_zero) begin
                  // Leaving dead time: the new direction is safe, ramp up from zero.
                  state_nx      = ST_RUN;
                  brake_req_nx  = 1'b0;
                  applied_nx    = restart;
                  last_valid_nx = (restart != 8'sd0);
                  last_neg_nx   = restart[7];
               end
            end
            ST_RUN: begin
               if (i_Brake) begin
                  state_nx     = ST_DEAD;
                  dead_nx      = DEAD_LOAD;
                  brake_req_nx = 1'b1;
                  applied_nx   = 8'sd0;
               end else if (at_zero) begin
                  if (reversal) begin
                     state_nx      = ST_DEAD;
                     dead_nx       = DEAD_LOAD;
                     last_valid_nx = 1'b0;
                  end else begin
                     applied_nx = ramped;
                     if (ramped != 8'sd0) begin
                        last_valid_nx = 1'b1;
                        last_neg_nx   = ramped[7];
                     end
                  end
               end
            end
            ST_BRAKE: begin
               applied_nx = 8'sd0;
               if (!i_Brake) begin
                  state_nx     = ST_DEAD;
                  dead_nx      = DEAD_LOAD;
                  brake_req_nx = 1'b0;
               end
            end
            default: begin
               state_nx   = ST_IDLE;
               applied_nx = 8'sd0;
            end
         endcase
      end
   end

   // Output decode from the next state so outputs change on the same edge as the state.
   always_comb begin
      ps_nx      = i_Enable && at_zero;
      cw_nx      = 1'b0;
      ccw_nx     = 1'b0;
      braking_nx = 1'b0;
      duty_neg   = -applied_nx;
      duty_abs   = applied_nx[7] ? duty_neg : applied_nx;
      thresh     = TH_W'(duty_abs) * STEP_TH;
      case (state_nx)
         ST_RUN: begin
            cw_nx  = !applied_nx[7] && (applied_nx != 8'sd0) && (TH_W'(cnt) < thresh);
            ccw_nx = applied_nx[7] && (TH_W'(cnt) < thresh);
         end
         ST_BRAKE: begin
            cw_nx      = 1'b1;
            ccw_nx     = 1'b1;
            braking_nx = 1'b1;
         end
         default: begin
            cw_nx  = 1'b0;
            ccw_nx = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops every output immediately.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state              <= ST_IDLE;
         cnt                <= '0;
         dead_cnt           <= '0;
         applied            <= 8'sd0;
         brake_req          <= 1'b0;
         last_valid         <= 1'b0;
         last_neg           <= 1'b0;
         o_Clockwise        <= 1'b0;
         o_Counterclockwise <= 1'b0;
         o_Period_Start     <= 1'b0;
         o_Duty_Applied     <= 8'sd0;
         o_Braking          <= 1'b0;
      end else begin
         state              <= state_nx;
         cnt                <= cnt_nx;
         dead_cnt           <= dead_nx;
         applied            <= applied_nx;
         brake_req          <= brake_req_nx;
         last_valid         <= last_valid_nx;
         last_neg           <= last_neg_nx;
         o_Clockwise        <= cw_nx;
         o_Counterclockwise <= ccw_nx;
         o_Period_Start     <= ps_nx;
         o_Duty_Applied     <= applied_nx;
         o_Braking          <= braking_nx;
      end
   end

endmodule

// File: tb/tb_dc_motor_pwm_ctrl.sv
// Directed bench for dc_motor_pwm_ctrl. One instance runs without a slew
// limit, a second with RAMP_STEP=10; both see the same inputs and the
// checks pick whichever instance the current scenario is about.
module tb_dc_motor_pwm_ctrl;

   localparam int PERIOD = 1000;
   localparam int DEAD   = 20;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              en    = 1'b0;
   logic              brk   = 1'b0;
   logic signed [7:0] spd   = 8'sd0;

   logic              cw0, ccw0, ps0, brk0;
   logic signed [7:0] duty0;
   logic              cw1, ccw1, ps1, brk1;
   logic signed [7:0] duty1;

   bit                sel = 1'b0;
   logic              cw_s, ccw_s, ps_s, brk_s;
   logic signed [7:0] duty_s;

   int n_chk = 0;
   int n_bad = 0;
   int viol  = 0;

   always #5 clk = ~clk;

   dc_motor_pwm_ctrl #(.PERIOD_CYCLES(PERIOD), .DEAD_CYCLES(DEAD), .RAMP_STEP(0)) dut_fix (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Brake(brk), .i_Speed(spd),
      .o_Clockwise(cw0), .o_Counterclockwise(ccw0), .o_Period_Start(ps0),
      .o_Duty_Applied(duty0), .o_Braking(brk0)
   );

   dc_motor_pwm_ctrl #(.PERIOD_CYCLES(PERIOD), .DEAD_CYCLES(DEAD), .RAMP_STEP(10)) dut_ramp (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Brake(brk), .i_Speed(spd),
      .o_Clockwise(cw1), .o_Counterclockwise(ccw1), .o_Period_Start(ps1),
      .o_Duty_Applied(duty1), .o_Braking(brk1)
   );

   always_comb begin
      cw_s   = sel ? cw1   : cw0;
      ccw_s  = sel ? ccw1  : ccw0;
      ps_s   = sel ? ps1   : ps0;
      brk_s  = sel ? brk1  : brk0;
      duty_s = sel ? duty1 : duty0;
   end

   // Both drive outputs high together only while braking.
   always @(negedge clk) begin
      if (rst_n && ((cw0 && ccw0 && !brk0) || (cw1 && ccw1 && !brk1)))
         viol++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ps(input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (ps_s) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit)
         chk({tag, "_timeout"}, 0, 1);
   endtask

   // what: 0 = clockwise high, 1 = counterclockwise high, 2 = both high.
   task automatic wait_on(input string tag, input int what, output int n);
      bit hit;
      hit = 1'b0;
      n   = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         case (what)
            0:       hit = cw_s;
            1:       hit = ccw_s;
            default: hit = cw_s && ccw_s;
         endcase
         if (hit)
            break;
         n++;
      end
      if (!hit)
         chk({tag, "_timeout"}, 0, 1);
   endtask

   // Counts high cycles over one period, starting at the current (period-start) sample.
   task automatic measure(output int hcw, output int hccw);
      hcw  = 0;
      hccw = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (cw_s)  hcw++;
         if (ccw_s) hccw++;
         if (i != PERIOD - 1)
            @(negedge clk);
      end
   endtask

   int ramp_exp[4] = '{10, 20, 30, 35};
   int hcw, hccw, n;

   initial begin
      // Reset values
      step(3);
      chk("rst_cw", cw0, 0);
      chk("rst_ccw", ccw0, 0);
      chk("rst_ps", ps0, 0);
      chk("rst_duty", duty0, 0);
      chk("rst_braking", brk0, 0);

      // Slew-limited ramp 0 -> +35 on the RAMP_STEP=10 instance
      sel   = 1'b1;
      rst_n = 1'b1;
      en    = 1'b1;
      spd   = 8'sd0;
      wait_ps("t2_a");
      wait_ps("t2_b");
      chk("t2_duty0", duty_s, 0);
      spd = 8'sd35;
      for (int k = 0; k < 4; k++) begin
         wait_ps("t2_ps");
         chk("t2_duty", duty_s, ramp_exp[k]);
         measure(hcw, hccw);
         chk("t2_high", hcw, ramp_exp[k] * 10);
         chk("t2_ccw", hccw, 0);
      end

      // Startup and fixed duty on the unlimited instance
      en    = 1'b0;
      rst_n = 1'b0;
      step(2);
      sel   = 1'b0;
      rst_n = 1'b1;
      en    = 1'b1;
      spd   = 8'sd50;
      wait_on("t1_start", 0, n);
      chk("t1_low_window", int'(n >= DEAD && n <= DEAD + PERIOD + 2), 1);
      chk("t1_ps_align", ps_s, 1);
      chk("t1_duty", duty_s, 50);
      measure(hcw, hccw);
      chk("t1_high_a", hcw, 500);
      chk("t1_ccw", hccw, 0);
      wait_ps("t1_ps");
      measure(hcw, hccw);
      chk("t1_high_b", hcw, 500);

      // Reversal +50 -> -25; mid-period change has no effect
      wait_ps("t3_a");
      chk("t3_duty50", duty_s, 50);
      spd = -8'sd25;
      measure(hcw, hccw);
      chk("t3_midperiod", hcw, 500);
      wait_ps("t3_b");
      chk("t3_duty_zero", duty_s, 0);
      measure(hcw, hccw);
      chk("t3_zero_cw", hcw, 0);
      chk("t3_zero_ccw", hccw, 0);
      wait_ps("t3_c");
      chk("t3_dead_duty", duty_s, 0);
      measure(hcw, hccw);
      chk("t3_dead_both", hcw + hccw, 0);
      wait_ps("t3_d");
      chk("t3_duty_neg", duty_s, -25);
      measure(hcw, hccw);
      chk("t3_ccw_high", hccw, 250);
      chk("t3_cw_low", hcw, 0);

      // Clamp of -128 and 100 % continuity across wraps, then zero command
      wait_ps("t4_a");
      spd = -8'sd128;
      measure(hcw, hccw);
      chk("t4_prev", hccw, 250);
      wait_ps("t4_b");
      chk("t4_duty_clamp", duty_s, -100);
      measure(hcw, hccw);
      chk("t4_full_a", hccw, 1000);
      wait_ps("t4_c");
      measure(hcw, hccw);
      chk("t4_full_b", hccw, 1000);
      chk("t4_cw", hcw, 0);
      spd = 8'sd0;
      wait_ps("t4_d");
      chk("t4_duty_zero", duty_s, 0);
      measure(hcw, hccw);
      chk("t4_zero_both", hcw + hccw, 0);

      // Brake from RUN at +50
      spd = 8'sd50;
      wait_ps("t5_a");
      chk("t5_rev_duty", duty_s, 0);
      wait_ps("t5_b");
      chk("t5_duty50", duty_s, 50);
      step(100);
      chk("t5_pulse", cw_s, 1);
      brk = 1'b1;
      step(1);
      chk("t5_low_next", cw_s, 0);
      chk("t5_ccw_next", ccw_s, 0);
      wait_on("t5_brake", 2, n);
      chk("t5_dead_len", int'(n + 1 >= DEAD && n + 1 <= DEAD + 1), 1);
      chk("t5_braking", brk_s, 1);
      chk("t5_brake_duty", duty_s, 0);
      step(50);
      chk("t5_hold", int'(cw_s && ccw_s && brk_s), 1);
      brk = 1'b0;
      step(1);
      chk("t5_rel_cw", cw_s, 0);
      chk("t5_rel_braking", brk_s, 0);
      chk("t5_rel_duty", duty_s, 0);
      wait_on("t5_restart", 0, n);
      chk("t5_rel_dead", int'(n + 1 >= DEAD), 1);
      chk("t5_restart_ps", ps_s, 1);
      chk("t5_restart_duty", duty_s, 50);

      // Enable drop and asynchronous reset mid-pulse
      step(100);
      chk("t6_pulse", cw_s, 1);
      en = 1'b0;
      step(1);
      chk("t6_dis_cw", cw_s, 0);
      chk("t6_dis_duty", duty_s, 0);
      en = 1'b1;
      wait_on("t6_resume", 0, n);
      step(100);
      chk("t6_pulse_b", cw_s, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_cw", cw_s, 0);
      chk("t6_rst_duty", duty_s, 0);
      step(2);
      rst_n = 1'b1;

      chk("exclusive", viol, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
